// File: rtl/dna_loader_if.sv
// Handshake bundle for dna_loader: control, shared RAM bus and gene stream.
// The master side is the loader; the slave side is the surrounding system.
interface dna_loader_if #(
  parameter int unsigned NET_W = 4
);
  logic             start;
  logic [NET_W-1:0] netIndex;
  logic             busy;
  logic             done;
  logic [23:1]      ramBusAddr;
  logic [15:0]      ramBusDataOut;
  logic             ramLatch;
  logic             ramReady;
  logic             ramInstruction;
  logic [15:0]      geneData;
  logic [15:0]      geneIndex;
  logic             geneValid;
  logic             geneLast;
  logic             geneReady;

  modport master (
    input  start, netIndex, ramBusDataOut, ramReady, geneReady,
    output busy, done, ramBusAddr, ramLatch, ramInstruction,
           geneData, geneIndex, geneValid, geneLast
  );

  modport slave (
    output start, netIndex, ramBusDataOut, ramReady, geneReady,
    input  busy, done, ramBusAddr, ramLatch, ramInstruction,
           geneData, geneIndex, geneValid, geneLast
  );
endinterface

// File: rtl/dna_loader.sv
// Reads one network's genes back from RAM and streams them in order to the
// evaluator through a 2-entry FIFO, so RAM reads overlap consumer stalls.
module dna_loader #(
  parameter int unsigned OUTPUT_COUNT            = 1,
  parameter int unsigned NEURON_COUNT            = 2,
  parameter int unsigned CONNECTIONS             = 2,
  parameter int unsigned NETWORKS_PER_POPULATION = 16,
  parameter int unsigned NET_W                   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dna_loader_if.master  bus
);
  localparam int unsigned GENES    = OUTPUT_COUNT + NEURON_COUNT * CONNECTIONS;
  localparam logic [15:0] GENES_W  = 16'(GENES);
  localparam logic [15:0] LAST_IDX = 16'(GENES - 1);

  if ((1 << NET_W) < NETWORKS_PER_POPULATION) begin : g_net_w_check
    $error("NET_W too narrow to address NETWORKS_PER_POPULATION networks");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DATA, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [22:0] base_q, base_d;
  logic [15:0] req_cnt_q, req_cnt_d;
  logic [15:0] push_idx_q, push_idx_d;
  logic [15:0] fifo_data_q [2];
  logic [15:0] fifo_data_d [2];
  logic [15:0] fifo_idx_q [2];
  logic [15:0] fifo_idx_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ram_latch_q, ram_latch_d;
  logic [22:0] ram_addr_q, ram_addr_d;
  logic [15:0] gene_data_q, gene_data_d;
  logic [15:0] gene_index_q, gene_index_d;
  logic        gene_valid_q, gene_valid_d;
  logic        gene_last_q, gene_last_d;
  logic        push, pop, accept;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    req_cnt_d    = req_cnt_q;
    push_idx_d   = push_idx_q;
    fifo_data_d  = fifo_data_q;
    fifo_idx_d   = fifo_idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ram_latch_d  = 1'b0;
    ram_addr_d   = ram_addr_q;
    gene_data_d  = gene_data_q;
    gene_index_d = gene_index_q;
    push         = 1'b0;
    accept       = 1'b0;
    pop          = gene_valid_q && bus.geneReady;

    case (state_q)
      // A start landing on the done cycle is dropped.
      IDLE: if (bus.start && !done_q) begin
        accept     = 1'b1;
        base_d     = 23'(bus.netIndex) * 23'(GENES) + 23'd1;
        req_cnt_d  = '0;
        push_idx_d = '0;
        busy_d     = 1'b1;
        state_d    = ISSUE;
      end
      // Only one read is ever outstanding, so a free slot now stays free.
      ISSUE: if (bus.ramReady && (req_cnt_q < GENES_W) && (occ_q != 2'd2)) begin
        ram_addr_d  = base_q + 23'(req_cnt_q);
        ram_latch_d = 1'b1;
        req_cnt_d   = req_cnt_q + 16'd1;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: if (!bus.ramReady) state_d = WAIT_DATA;
      WAIT_DATA: if (bus.ramReady) begin
        push    = 1'b1;
        state_d = (req_cnt_q < GENES_W) ? ISSUE : DRAIN;
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.ramBusDataOut;
      fifo_idx_d[wr_ptr_q]  = push_idx_q;
      wr_ptr_d              = ~wr_ptr_q;
      push_idx_d            = push_idx_q + 16'd1;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: ;
    endcase

    if ((state_q == DRAIN) && (occ_d == 2'd0)) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end

    // Gene outputs mirror the next FIFO head so they change with the flops.
    gene_valid_d = (occ_d != 2'd0);
    if (gene_valid_d) begin
      gene_data_d  = fifo_data_d[rd_ptr_d];
      gene_index_d = fifo_idx_d[rd_ptr_d];
    end else if (accept) begin
      gene_index_d = '0;
    end
    gene_last_d = gene_valid_d && (fifo_idx_d[rd_ptr_d] == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      req_cnt_q    <= '0;
      push_idx_q   <= '0;
      fifo_data_q  <= '{default: '0};
      fifo_idx_q   <= '{default: '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ram_latch_q  <= 1'b0;
      ram_addr_q   <= '0;
      gene_data_q  <= '0;
      gene_index_q <= '0;
      gene_valid_q <= 1'b0;
      gene_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      req_cnt_q    <= req_cnt_d;
      push_idx_q   <= push_idx_d;
      fifo_data_q  <= fifo_data_d;
      fifo_idx_q   <= fifo_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ram_latch_q  <= ram_latch_d;
      ram_addr_q   <= ram_addr_d;
      gene_data_q  <= gene_data_d;
      gene_index_q <= gene_index_d;
      gene_valid_q <= gene_valid_d;
      gene_last_q  <= gene_last_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.ramLatch       = ram_latch_q;
  assign bus.ramBusAddr     = ram_addr_q;
  assign bus.ramInstruction = 1'b0;
  assign bus.geneData       = gene_data_q;
  assign bus.geneIndex      = gene_index_q;
  assign bus.geneValid      = gene_valid_q;
  assign bus.geneLast       = gene_last_q;
endmodule

// File: tb/tb_dna_loader.sv
// Directed bench for dna_loader: RAM responder, gene logger and per-load
// checks against hand-computed addresses (gene k of net n at n*5 + k + 1).
module tb_dna_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dna_loader_if #(.NET_W(4)) bus();

  dna_loader #(
    .OUTPUT_COUNT(1),
    .NEURON_COUNT(2),
    .CONNECTIONS(2),
    .NETWORKS_PER_POPULATION(16),
    .NET_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned ram_lat = 2;
  int unsigned rdy_mode = 1;
  int unsigned addr_log[$];
  logic [15:0] gd_log[$];
  logic [15:0] gi_log[$];
  logic        gl_log[$];
  int unsigned done_cnt = 0;
  int unsigned latch_cnt = 0;
  int unsigned instr_err = 0;
  int unsigned a0, g0, d0, l0;

  function automatic logic [15:0] ram_word(input int unsigned a);
    return 16'((a * 32'h0131) ^ 32'hA55A);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM responder: ready drops the cycle after the latch, data follows ram_lat cycles later.
  initial begin : ram_model
    int unsigned a;
    bus.ramReady = 1'b1;
    bus.ramBusDataOut = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.ramLatch) begin
        a = 32'(bus.ramBusAddr);
        addr_log.push_back(a);
        @(posedge clk); #1;
        bus.ramReady = 1'b0;
        bus.ramBusDataOut = 16'hDEAD;
        repeat (ram_lat) @(posedge clk);
        #1;
        bus.ramBusDataOut = ram_word(a);
        bus.ramReady = 1'b1;
      end
    end
  end

  initial begin : ready_driver
    int unsigned ph;
    ph = 0;
    bus.geneReady = 1'b0;
    forever begin
      @(posedge clk); #1;
      ph++;
      case (rdy_mode)
        0:       bus.geneReady = 1'b0;
        1:       bus.geneReady = 1'b1;
        default: bus.geneReady = ((ph % 5) == 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.geneValid && bus.geneReady) begin
        gd_log.push_back(bus.geneData);
        gi_log.push_back(bus.geneIndex);
        gl_log.push_back(bus.geneLast);
      end
      if (bus.done) done_cnt++;
      if (bus.ramLatch) latch_cnt++;
      if (bus.ramInstruction !== 1'b0) instr_err++;
    end
  end

  task automatic snapshot();
    a0 = addr_log.size();
    g0 = gd_log.size();
    d0 = done_cnt;
    l0 = latch_cnt;
  endtask

  task automatic kick(input string tag, input logic [3:0] net);
    @(negedge clk);
    bus.netIndex = net;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        check({tag, "_busy_with_done"}, 32'(bus.busy), 32'd0);
        if (poke) begin
          bus.netIndex = 4'd9;
          bus.start = 1'b1;
          @(negedge clk);
          bus.start = 1'b0;
          check({tag, "_start_on_done_ignored"}, 32'(bus.busy), 32'd0);
        end
        break;
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_load(input string tag, input int unsigned first);
    check({tag, "_nreads"}, 32'(addr_log.size() - a0), 32'd5);
    check({tag, "_nlatch"}, 32'(latch_cnt - l0), 32'd5);
    check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_ngenes"}, 32'(gd_log.size() - g0), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (a0 + k < addr_log.size())
        check($sformatf("%s_addr%0d", tag, k), addr_log[a0 + k], first + k);
      if (g0 + k < gd_log.size()) begin
        check($sformatf("%s_data%0d", tag, k), 32'(gd_log[g0 + k]), 32'(ram_word(first + k)));
        check($sformatf("%s_idx%0d", tag, k), 32'(gi_log[g0 + k]), k);
        check($sformatf("%s_last%0d", tag, k), 32'(gl_log[g0 + k]), (k == 4) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned stable_err;
    logic [15:0] first_data;
    bus.start = 1'b0;
    bus.netIndex = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_latch", 32'(bus.ramLatch), 32'd0);
    check("rst_instr", 32'(bus.ramInstruction), 32'd0);
    check("rst_addr", 32'(bus.ramBusAddr), 32'd0);
    check("rst_valid", 32'(bus.geneValid), 32'd0);
    check("rst_last", 32'(bus.geneLast), 32'd0);
    check("rst_data", 32'(bus.geneData), 32'd0);
    check("rst_index", 32'(bus.geneIndex), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    snapshot(); kick("n3", 4'd3); wait_done("n3", 1'b0); check_load("n3", 16);
    snapshot(); kick("n0", 4'd0); wait_done("n0", 1'b0); check_load("n0", 1);
    snapshot(); kick("n15", 4'd15); wait_done("n15", 1'b0); check_load("n15", 76);

    // Consumer stalled for 20 cycles after the first gene shows up.
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    snapshot(); kick("bp", 4'd4);
    for (int i = 0; i < 100; i++) begin
      if (bus.geneValid) break;
      @(negedge clk);
    end
    check("bp_first_valid", 32'(bus.geneValid), 32'd1);
    first_data = bus.geneData;
    check("bp_first_data", 32'(first_data), 32'(ram_word(21)));
    stable_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.geneData !== first_data || bus.geneIndex !== 16'd0 || bus.geneValid !== 1'b1)
        stable_err++;
    end
    check("bp_head_stable", stable_err, 32'd0);
    check("bp_reads_while_stalled", 32'(latch_cnt - l0), 32'd2);
    rdy_mode = 1;
    wait_done("bp", 1'b0); check_load("bp", 21);

    // Second start mid-load must not redirect the reads.
    snapshot(); kick("mid", 4'd2);
    repeat (4) @(negedge clk);
    bus.netIndex = 4'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_busy_held", 32'(bus.busy), 32'd1);
    wait_done("mid", 1'b0); check_load("mid", 11);

    snapshot(); kick("pk", 4'd1); wait_done("pk", 1'b1); check_load("pk", 6);

    // Reset while the second read is outstanding; its data lands after release.
    rdy_mode = 0;
    ram_lat = 6;
    repeat (2) @(negedge clk);
    kick("rs", 4'd5);
    for (int i = 0; i < 100; i++) begin
      if (bus.geneValid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 100; i++) begin
      if (!bus.ramReady) break;
      @(negedge clk);
    end
    check("rs_second_read_pending", 32'(bus.ramReady), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rs_busy", 32'(bus.busy), 32'd0);
    check("rs_valid", 32'(bus.geneValid), 32'd0);
    check("rs_data", 32'(bus.geneData), 32'd0);
    check("rs_index", 32'(bus.geneIndex), 32'd0);
    check("rs_last", 32'(bus.geneLast), 32'd0);
    check("rs_addr", 32'(bus.ramBusAddr), 32'd0);
    check("rs_latch", 32'(bus.ramLatch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rs_late_ready_seen", 32'(bus.ramReady), 32'd1);
    check("rs_late_not_captured", 32'(bus.geneValid), 32'd0);
    check("rs_idle_busy", 32'(bus.busy), 32'd0);
    ram_lat = 2;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    snapshot(); kick("rs2", 4'd5); wait_done("rs2", 1'b0); check_load("rs2", 26);

    // Sparse consumer so pushes and pops collide with one entry held.
    rdy_mode = 2;
    ram_lat = 1;
    snapshot(); kick("sp1", 4'd6); wait_done("sp1", 1'b0); check_load("sp1", 31);
    ram_lat = 2;
    snapshot(); kick("sp2", 4'd8); wait_done("sp2", 1'b0); check_load("sp2", 41);
    ram_lat = 3;
    snapshot(); kick("sp3", 4'd10); wait_done("sp3", 1'b0); check_load("sp3", 51);

    check("instr_always_read", instr_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/dna_loader.md
Name: dna_loader

Overview:
- Reads one network's DNA (genes written to RAM by the DNA initializer) back out of external RAM over the shared RAM handshake bus.
- Streams the genes, in order, to the network evaluator through a valid/ready interface.
- Sits directly downstream of the initializer in the population flow: init → load → evaluate.
- A 2-entry FIFO lets RAM reads overlap with evaluator back-pressure.

Parameters:
- OUTPUT_COUNT, 1, network outputs.
- NEURON_COUNT, 2, neurons per network.
- CONNECTIONS, 2, inputs per neuron.
- NETWORKS_PER_POPULATION, 16, networks stored in RAM.
- NET_W, 4, width of netIndex; must satisfy 2^NET_W >= NETWORKS_PER_POPULATION.
- Derived, not overridable: GENES = OUTPUT_COUNT + NEURON_COUNT*CONNECTIONS.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to load netIndex; ignored while busy=1.
- netIndex  in  NET_W  network to load; sampled on the accepted start.
- busy  out  1  high from the accepted start until the last gene is handed off.
- done  out  1  one-cycle pulse, the cycle after the last gene handshake.
- ramBusAddr  out  23 ([23:1])  RAM word address.
- ramBusDataOut  in  16  RAM read data.
- ramLatch  out  1  one-cycle command strobe.
- ramReady  in  1  RAM idle/data-valid.
- ramInstruction  out  1  always READ (0).
- geneData  out  16  FIFO head gene.
- geneIndex  out  16  position of the head gene within the network, 0..GENES-1.
- geneValid  out  1  FIFO non-empty.
- geneLast  out  1  head gene is index GENES-1.
- geneReady  in  1  consumer accepts the head gene when geneValid=1.

Behaviour:
- Reset values (asynchronous):
  - busy=0, done=0, ramLatch=0, ramInstruction=0, ramBusAddr=0.
  - geneValid=0, geneLast=0, geneData=0, geneIndex=0.
  - FIFO empty; FSM in IDLE.
- Address map matches the initializer: gene k of network n is at address n*GENES + k + 1.
  - Compute the address in 23 bits; no wrap for legal parameters.
- FSM states:
  - IDLE: start=1 → latch base=netIndex*GENES+1, reqCount=0, busy=1, go to ISSUE.
  - ISSUE: wait until ramReady=1, reqCount<GENES and the FIFO has a free slot (counting the in-flight read).
    - Then drive ramBusAddr=base+reqCount, ramInstruction=READ, ramLatch=1 for exactly one cycle.
    - reqCount++, go to WAIT_BUSY.
  - WAIT_BUSY: wait for ramReady=0, then go to WAIT_DATA.
  - WAIT_DATA: on the first cycle ramReady=1, capture ramBusDataOut into the FIFO tail.
    - Go to ISSUE if reqCount<GENES, else go to DRAIN.
  - DRAIN: stay until the FIFO is empty and the last gene has been handed off.
    - Then pulse done=1 for one cycle, set busy=0, return to IDLE.
- RAM rule: ramReady falls no earlier than the cycle after the latch; the loader never issues a second latch before the previous read's data is captured.
- FIFO: 2 entries, with an occupancy counter and an index counter per entry.
  - A pop happens when geneValid && geneReady.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - Pushing when full is impossible by construction (the slot is reserved at ISSUE).
- Outputs are registered from FIFO state; geneData/geneIndex are held stable while geneValid=1 && geneReady=0.
- geneIndex counts pops from 0 and resets to 0 on each accepted start.
- start while busy: ignored, no state change.
- start and the done cycle coincident: start is ignored; a new start is accepted from the next cycle in IDLE.
- rst_n low mid-operation: all state returns to reset values immediately.
  - Any outstanding RAM read is abandoned; its later data is not captured.
- GENES=1: a single read; geneLast=1 on the only gene.

Test Plan:
- Defaults (GENES=5), start with netIndex=3, geneReady=1, RAM responds 2 cycles after the latch → reads at addresses 16..20 in order; genes appear with geneIndex 0..4; geneLast only on index 4; done pulses once; busy falls with done.
- netIndex=0 and netIndex=15 → first address 1, last address 80; data matches the RAM model.
- geneReady held 0 for 20 cycles after the first gene → exactly 2 reads issued, then ramLatch stays 0; geneData stable; after release the remaining 3 reads complete and all 5 genes arrive in order.
- start pulsed again mid-load with netIndex=7 → ignored; addresses stay on the original network; single done.
- rst_n asserted in WAIT_DATA → all outputs return to reset values at once; a late ramReady/data pulse is not captured; a new start afterwards loads correctly from gene 0.
- Same cycle pop and push with the FIFO holding 1 entry → occupancy stays 1; no gene lost or duplicated (scoreboard checks all genes).
